// File: rtl/uart_tx_arbiter_pkg.sv
// Package: uart_tx_arbiter_pkg
// Shared definitions for the UART transmit arbiter and its slot timer.
// - Arbiter FSM state encoding.
// - Default clock and UART rate values, which uart_send also uses so the
//   two blocks cannot be built with different rates.
// - Helper that computes the slot length in clock cycles.

package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam int DEF_CLK_FREQ   = 100_000_000;
  localparam int DEF_BAUD       = 9600;
  localparam int DEF_FRAME_BITS = 10;
  localparam int DEF_GAP_BITS   = 1;

  // One slot covers the whole frame plus the idle guard bits.
  function automatic int slot_cycles(input int clk_freq, input int baud,
                                     input int frame_bits, input int gap_bits);
    return (clk_freq / baud) * (frame_bits + gap_bits);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_slot_timer.sv
// Module: uart_tx_arbiter_slot_timer
// Reusable down-counter for UART frame pacing.
// Ports:
//   clk      in  1  system clock
//   rst      in  1  asynchronous reset, active-high (count cleared)
//   load     in  1  load load_val into the counter (takes priority over en)
//   en       in  1  decrement by one; holds at zero, never wraps
//   load_val in  W  value to load
//   done     out 1  counter is at zero

module uart_tx_arbiter_slot_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Module: uart_tx_arbiter
// Shares one uart_send transmitter between two byte producers. uart_send has
// no busy output, so this block times each frame slot (frame + guard bits)
// itself and refuses to issue again until the slot has elapsed.
// Optional feature macro: UART_ARB_RR_EN
//   defined   -> round-robin on ties, using a last-issued pointer
//   undefined -> fixed priority, req0 beats req1
// Handshake: reqN is a level request held with a stable dataN until the
//   one-cycle gntN pulse; the requester may change req/data from the cycle
//   after gntN. tx_valid is a one-cycle start pulse for uart_send, and
//   tx_data is held from that pulse until the next issue.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   req0/data0/gnt0     requester 0 request, byte, accept pulse
//   req1/data1/gnt1     requester 1 request, byte, accept pulse
//   tx_valid/tx_data    start pulse and byte to uart_send
//   busy                high while a slot is in progress
//   grant_id            requester of the last issued byte

module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int CLK_FREQ   = DEF_CLK_FREQ,
  parameter int BAUD       = DEF_BAUD,
  parameter int FRAME_BITS = DEF_FRAME_BITS,
  parameter int GAP_BITS   = DEF_GAP_BITS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [7:0] data0,
  output logic       gnt0,
  input  logic       req1,
  input  logic [7:0] data1,
  output logic       gnt1,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       grant_id
);

  localparam int SLOT_CYCLES = slot_cycles(CLK_FREQ, BAUD, FRAME_BITS, GAP_BITS);
  localparam int CW          = (SLOT_CYCLES < 2) ? 1 : $clog2(SLOT_CYCLES);
  // ISSUE takes one cycle and the counter spends one cycle at zero, so the
  // load value is two short of the slot length.
  localparam logic [CW-1:0] LOAD_VAL = CW'(SLOT_CYCLES - 2);

  if (SLOT_CYCLES < 2) begin : g_slot_check
    $error("uart_tx_arbiter: SLOT_CYCLES must be >= 2");
  end

  state_t state, state_nxt;
  logic   issue;
  logic   winner;
  logic   timer_load;
  logic   timer_en;
  logic   timer_done;

  // ---------------- arbitration ----------------
`ifdef UART_ARB_RR_EN
  logic last_ptr;

  always_comb begin
    winner = req1;
    if (req0 && req1) begin
      winner = ~last_ptr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_ptr <= 1'b1;
    end else if (issue) begin
      last_ptr <= winner;
    end
  end
`else
  // req0 wins whenever it is present.
  always_comb begin
    winner = ~req0;
  end
`endif

  // ---------------- FSM next state ----------------
  always_comb begin
    state_nxt  = state;
    issue      = 1'b0;
    timer_load = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req0 || req1) begin
          issue     = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        timer_load = 1'b1;
        state_nxt  = ST_WAIT;
      end
      ST_WAIT: begin
        if (timer_done) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign timer_en = (state == ST_WAIT);

  uart_tx_arbiter_slot_timer #(
    .W (CW)
  ) u_slot_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .en       (timer_en),
    .load_val (LOAD_VAL),
    .done     (timer_done)
  );

  // ---------------- state and registered outputs ----------------
  // Outputs are computed from the next state so they line up with it:
  // tx_valid/gnt are high exactly during ISSUE, busy during ISSUE and WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      tx_valid <= 1'b0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      busy     <= 1'b0;
      grant_id <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      state    <= state_nxt;
      tx_valid <= issue;
      gnt0     <= issue & ~winner;
      gnt1     <= issue & winner;
      busy     <= (state_nxt != ST_IDLE);
      if (issue) begin
        tx_data  <= winner ? data1 : data0;
        grant_id <= winner;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter with CLK_FREQ=1000, BAUD=100, so one slot is
// 110 cycles and back-to-back issues are 111 cycles apart.

module tb_uart_tx_arbiter;

  localparam int SLOT   = 110;
  localparam int PERIOD = SLOT + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [7:0] data0, data1;
  logic       gnt0, gnt1, tx_valid, busy, grant_id;
  logic [7:0] tx_data;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic       model_last;
  logic [7:0] exp_q[$];

  uart_tx_arbiter #(
    .CLK_FREQ   (1000),
    .BAUD       (100),
    .FRAME_BITS (10),
    .GAP_BITS   (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req0     (req0),
    .data0    (data0),
    .gnt0     (gnt0),
    .req1     (req1),
    .data1    (data1),
    .gnt1     (gnt1),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .busy     (busy),
    .grant_id (grant_id)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    model_last = 1'b1;
  endtask

  // Expected tie winner from the bench's own pointer model.
  function automatic logic tie_winner();
`ifdef UART_ARB_RR_EN
    return ~model_last;
`else
    return 1'b0;
`endif
  endfunction

  task automatic wait_valid(input int limit, output bit seen, output int t);
    seen = 1'b0;
    t    = 0;
    for (int i = 0; i < limit; i++) begin
      step();
      if (tx_valid) begin
        seen = 1'b1;
        t    = cyc;
        break;
      end
    end
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!busy) begin
        done = 1'b1;
        break;
      end
      step();
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s_idle_timeout: busy=%b required 0 within 300 cycles", name, busy);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; data0 = 8'h00; data1 = 8'h00;
    step();
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b required 0", tx_valid); end
    n_checks++; if (gnt0 !== 1'b0) begin n_fail++; $display("FAIL reset_gnt0: got %b required 0", gnt0); end
    n_checks++; if (gnt1 !== 1'b0) begin n_fail++; $display("FAIL reset_gnt1: got %b required 0", gnt1); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
    n_checks++; if (grant_id !== 1'b0) begin n_fail++; $display("FAIL reset_grant_id: got %b required 0", grant_id); end
    n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h required 00", tx_data); end
    rst = 1'b0;
    model_last = 1'b1;
  endtask

  task automatic test_idle();
    int bad = 0;
    for (int i = 0; i < 500; i++) begin
      step();
      if (tx_valid !== 1'b0 || gnt0 !== 1'b0 || gnt1 !== 1'b0 ||
          busy !== 1'b0 || tx_data !== 8'h00) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL idle_quiet: %0d active cycles, required 0", bad); end
  endtask

  task automatic test_single();
    int busy_cnt = 0;
    int pulses   = 0;
    req0 = 1'b1; data0 = 8'h41;
    step();
    n_checks++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL single_tx_valid: got %b required 1", tx_valid); end
    n_checks++; if (gnt0 !== 1'b1) begin n_fail++; $display("FAIL single_gnt0: got %b required 1", gnt0); end
    n_checks++; if (gnt1 !== 1'b0) begin n_fail++; $display("FAIL single_gnt1: got %b required 0", gnt1); end
    n_checks++; if (tx_data !== 8'h41) begin n_fail++; $display("FAIL single_tx_data: got %h required 41", tx_data); end
    n_checks++; if (grant_id !== 1'b0) begin n_fail++; $display("FAIL single_grant_id: got %b required 0", grant_id); end
    model_last = 1'b0;
    req0 = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (busy) busy_cnt++;
      if (tx_valid) pulses++;
      step();
    end
    n_checks++; if (busy_cnt != SLOT) begin n_fail++; $display("FAIL single_busy_len: got %0d required %0d", busy_cnt, SLOT); end
    n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL single_pulse_count: got %0d required 1", pulses); end
    n_checks++; if (tx_data !== 8'h41) begin n_fail++; $display("FAIL single_data_held: got %h required 41", tx_data); end
  endtask

  task automatic test_priority();
    logic w;
    bit   seen;
    int   t0, t1;
    req0 = 1'b1; req1 = 1'b1; data0 = 8'h31; data1 = 8'h32;
    w = tie_winner();
    step();
    t0 = cyc;
    n_checks++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL prio_first_valid: got %b required 1", tx_valid); end
    n_checks++; if (grant_id !== w) begin n_fail++; $display("FAIL prio_first_id: got %b required %b", grant_id, w); end
    n_checks++; if (tx_data !== (w ? 8'h32 : 8'h31)) begin n_fail++; $display("FAIL prio_first_data: got %h required %h", tx_data, (w ? 8'h32 : 8'h31)); end
    n_checks++; if ({gnt1, gnt0} !== (w ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL prio_first_gnt: got %b%b required %b", gnt1, gnt0, (w ? 2'b10 : 2'b01)); end
    model_last = w;
    if (w) req1 = 1'b0; else req0 = 1'b0;
    wait_valid(200, seen, t1);
    n_checks++; if (!seen) begin n_fail++; $display("FAIL prio_second_timeout: no tx_valid within 200 cycles"); end
    n_checks++; if (t1 - t0 != PERIOD) begin n_fail++; $display("FAIL prio_spacing: got %0d required %0d", t1 - t0, PERIOD); end
    n_checks++; if (grant_id !== ~w) begin n_fail++; $display("FAIL prio_second_id: got %b required %b", grant_id, ~w); end
    n_checks++; if (tx_data !== (w ? 8'h31 : 8'h32)) begin n_fail++; $display("FAIL prio_second_data: got %h required %h", tx_data, (w ? 8'h31 : 8'h32)); end
    model_last = ~w;
    req0 = 1'b0; req1 = 1'b0;
    wait_idle("prio");
  endtask

  task automatic test_back_to_back();
    logic       w;
    logic [7:0] exp;
    bit         seen;
    int         t, tprev;
    apply_reset();
    tprev = 0;
    req0 = 1'b1; req1 = 1'b1; data0 = 8'hA0; data1 = 8'hB1;
    for (int k = 0; k < 4; k++) begin
      w = tie_winner();
      exp_q.push_back(w ? 8'hB1 : 8'hA0);
      wait_valid(200, seen, t);
      n_checks++; if (!seen) begin n_fail++; $display("FAIL b2b_timeout: slot %0d no tx_valid", k); end
      n_checks++; if (grant_id !== w) begin n_fail++; $display("FAIL b2b_id: slot %0d got %b required %b", k, grant_id, w); end
      exp = exp_q.pop_front();
      n_checks++; if (tx_data !== exp) begin n_fail++; $display("FAIL b2b_data: slot %0d got %h required %h", k, tx_data, exp); end
      if (k > 0) begin
        n_checks++; if (t - tprev != PERIOD) begin n_fail++; $display("FAIL b2b_spacing: slot %0d got %0d required %0d", k, t - tprev, PERIOD); end
      end
      tprev = t;
      model_last = w;
    end
    req0 = 1'b0; req1 = 1'b0;
    wait_idle("b2b");
  endtask

  task automatic test_late_req();
    bit seen;
    int t0, t1;
    int early = 0;
    req0 = 1'b1; data0 = 8'h55;
    step();
    t0 = cyc;
    n_checks++; if (gnt0 !== 1'b1) begin n_fail++; $display("FAIL late_gnt0: got %b required 1", gnt0); end
    model_last = 1'b0;
    req0 = 1'b0;
    repeat (40) step();
    req1 = 1'b1; data1 = 8'h66;
    seen = 1'b0; t1 = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (tx_valid) begin
        seen = 1'b1;
        t1 = cyc;
        break;
      end
      if (gnt1) early++;
    end
    n_checks++; if (early != 0) begin n_fail++; $display("FAIL late_early_gnt1: got %0d pulses required 0", early); end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL late_timeout: no tx_valid within 200 cycles"); end
    n_checks++; if (t1 - t0 != PERIOD) begin n_fail++; $display("FAIL late_spacing: got %0d required %0d", t1 - t0, PERIOD); end
    n_checks++; if (gnt1 !== 1'b1) begin n_fail++; $display("FAIL late_gnt1: got %b required 1", gnt1); end
    n_checks++; if (tx_data !== 8'h66) begin n_fail++; $display("FAIL late_data: got %h required 66", tx_data); end
    model_last = 1'b1;
    req1 = 1'b0;
    wait_idle("late");
  endtask

  task automatic test_reset_mid_slot();
    req0 = 1'b1; data0 = 8'h77;
    step();
    n_checks++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_first_valid: got %b required 1", tx_valid); end
    req0 = 1'b0;
    repeat (10) step();
    req0 = 1'b1; data0 = 8'h88;
    repeat (40) step();
    rst = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b required 0", busy); end
    n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL rmid_tx_data: got %h required 00", tx_data); end
    n_checks++; if (grant_id !== 1'b0) begin n_fail++; $display("FAIL rmid_grant_id: got %b required 0", grant_id); end
    n_checks++; if ({tx_valid, gnt0, gnt1} !== 3'b000) begin n_fail++; $display("FAIL rmid_pulses: got %b required 000", {tx_valid, gnt0, gnt1}); end
    step();
    n_checks++; if ({busy, gnt0, tx_valid} !== 3'b000) begin n_fail++; $display("FAIL rmid_held: got %b required 000", {busy, gnt0, tx_valid}); end
    rst = 1'b0;
    model_last = 1'b1;
    #1;
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_release_valid: got %b required 0", tx_valid); end
    step();
    n_checks++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_reissue_valid: got %b required 1", tx_valid); end
    n_checks++; if (gnt0 !== 1'b1) begin n_fail++; $display("FAIL rmid_reissue_gnt0: got %b required 1", gnt0); end
    n_checks++; if (tx_data !== 8'h88) begin n_fail++; $display("FAIL rmid_reissue_data: got %h required 88", tx_data); end
    model_last = 1'b0;
    req0 = 1'b0;
    wait_idle("rmid");
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_idle();
    test_single();
    test_priority();
    test_back_to_back();
    test_late_req();
    test_reset_mid_slot();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
